// File: rtl/latency_miter_monitor.sv
// Lockstep latency comparator for N_CH replicated multi-cycle units; flags any channel whose
// request-to-result latency differs from channel 0. Optional opcode filter: LATENCY_MITER_OP_FILTER_EN.
module latency_miter_monitor #(
  parameter int unsigned N_CH    = 2,
  parameter int unsigned OP_W    = 4,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [OP_W-1:0]       in_op,
  input  logic [N_CH-1:0]       out_valid,
`ifdef LATENCY_MITER_OP_FILTER_EN
  input  logic [(1<<OP_W)-1:0]  op_cmp_en,
`endif
  output logic                  busy,
  output logic                  cmp_valid,
  output logic [N_CH-1:0]       cmp_mask,
  output logic                  mismatch,
  output logic [OP_W-1:0]       first_op,
  output logic [CNT_W-1:0]      first_lat0,
  output logic                  timeout,
  output logic                  proto_err,
  output logic [15:0]           txn_count
);

  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MEASURE = 2'd1,
    S_COMPARE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   lat_q [N_CH];
  logic [CNT_W-1:0]   lat_d [N_CH];
  logic [N_CH-1:0]    done_q, done_d;
  logic [OP_W-1:0]    op_q, op_d;
  logic               mismatch_q, mismatch_d;
  logic [OP_W-1:0]    first_op_q, first_op_d;
  logic [CNT_W-1:0]   first_lat0_q, first_lat0_d;
  logic               timeout_q, timeout_d;
  logic               proto_q, proto_d;
  logic [15:0]        txn_q, txn_d;

  logic               hit_to;
  logic               err_now;
  logic               cmp_en;
  logic [N_CH-1:0]    diff;
  logic [N_CH-1:0]    diff_en;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; done_d already includes completions from this cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (in_valid) state_d = S_MEASURE;
      S_MEASURE: if (&done_d) state_d = S_COMPARE;
      S_COMPARE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy      = (state_q != S_IDLE);
    cmp_valid = (state_q == S_COMPARE);
    cmp_mask  = cmp_valid ? diff_en : '0;
  end

`ifdef LATENCY_MITER_OP_FILTER_EN
  assign cmp_en = op_cmp_en[op_q];
`else
  assign cmp_en = 1'b1;
`endif

  always_comb begin
    diff = '0;
    for (int unsigned i = 1; i < N_CH; i++) begin
      diff[i] = (lat_q[i] != lat_q[0]);
    end
    diff_en = cmp_en ? diff : '0;
  end

  // Latency counters: pending channels count up and freeze on result or at TIMEOUT
  always_comb begin
    lat_d  = lat_q;
    done_d = done_q;
    op_d   = op_q;
    hit_to = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_d   = in_op;
          done_d = '0;
          for (int unsigned i = 0; i < N_CH; i++) begin
            lat_d[i] = '0;
          end
        end
      end
      S_MEASURE: begin
        for (int unsigned i = 0; i < N_CH; i++) begin
          if (!done_q[i]) begin
            lat_d[i] = lat_q[i] + CNT_W'(1);
            if (lat_d[i] == TO_VAL) begin
              hit_to    = 1'b1;
              done_d[i] = 1'b1;
            end
            if (out_valid[i]) begin
              done_d[i] = 1'b1;
            end
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    err_now = 1'b0;
    case (state_q)
      S_IDLE:    err_now = |out_valid;
      S_MEASURE: err_now = in_valid | (|(out_valid & done_q));
      S_COMPARE: err_now = in_valid | (|out_valid);
      default:   err_now = 1'b0;
    endcase
  end

  always_comb begin
    mismatch_d   = mismatch_q;
    first_op_d   = first_op_q;
    first_lat0_d = first_lat0_q;
    txn_d        = txn_q;
    timeout_d    = timeout_q | hit_to;
    proto_d      = proto_q | err_now;
    if (state_q == S_COMPARE) begin
      txn_d = txn_q + 16'd1;
      // Only the first diverging transaction is captured
      if ((|diff_en) && !mismatch_q) begin
        mismatch_d   = 1'b1;
        first_op_d   = op_q;
        first_lat0_d = lat_q[0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        lat_q[i] <= '0;
      end
      done_q       <= '0;
      op_q         <= '0;
      mismatch_q   <= 1'b0;
      first_op_q   <= '0;
      first_lat0_q <= '0;
      timeout_q    <= 1'b0;
      proto_q      <= 1'b0;
      txn_q        <= '0;
    end else begin
      lat_q        <= lat_d;
      done_q       <= done_d;
      op_q         <= op_d;
      mismatch_q   <= mismatch_d;
      first_op_q   <= first_op_d;
      first_lat0_q <= first_lat0_d;
      timeout_q    <= timeout_d;
      proto_q      <= proto_d;
      txn_q        <= txn_d;
    end
  end

  assign mismatch   = mismatch_q;
  assign first_op   = first_op_q;
  assign first_lat0 = first_lat0_q;
  assign timeout    = timeout_q;
  assign proto_err  = proto_q;
  assign txn_count  = txn_q;

endmodule

// File: doc/latency_miter_monitor.md
Name: latency_miter_monitor

Overview:
- Run-time/formal-friendly lockstep latency comparator for N_CH replicated copies of a multi-cycle functional unit (e.g. mul/div/shift) driven with identical op and control but differing secret operands.
- Measures per-channel request-to-result latency for each transaction and flags any divergence from channel 0. This is the generalised successor of the two-copy out_valid equality check.
- Sits beside the replicated units in simulation and in sby harnesses. Its sticky flags are asserted on directly.

Parameters:
- N_CH, 2, number of replicated channels compared; legal values are ≥2.
- OP_W, 4, width of the opcode recorded per transaction.
- CNT_W, 8, latency counter width.
- TIMEOUT, 255, latency at which a pending channel is declared hung; must satisfy TIMEOUT ≤ 2^CNT_W−1.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  transaction issued to all channels this cycle.
- in_op  in  OP_W  opcode of the issued transaction.
- out_valid  in  N_CH  per-channel result strobe.
- busy  out  1  transaction being measured.
- cmp_valid  out  1  one-cycle pulse: comparison result available.
- cmp_mask  out  N_CH  channels whose latency differs from channel 0; valid with cmp_valid. Bit 0 is always 0.
- mismatch  out  1  sticky: some compared transaction diverged.
- first_op  out  OP_W  opcode of the first diverging transaction.
- first_lat0  out  CNT_W  channel-0 latency of the first diverging transaction.
- timeout  out  1  sticky: a channel reached TIMEOUT.
- proto_err  out  1  sticky: in_valid while busy, or out_valid with no pending result on that channel.
- txn_count  out  16  completed comparisons; wraps at 0xFFFF→0.

Behaviour:
- Reset (async assert, sync deassert handled outside): all outputs 0.
  - FSM enters IDLE; counters and done bits clear.
  - Reset mid-MEASURE abandons the transaction; no cmp_valid is produced.
- FSM states: IDLE → MEASURE → COMPARE → IDLE. Only one transaction is outstanding at a time.
- IDLE:
  - in_valid=1 latches in_op, clears all lat[i] and done[i], and moves to MEASURE; busy=1 from the next cycle.
  - Any out_valid bit set in IDLE, including in the accept cycle, sets proto_err.
- MEASURE, each cycle, for each channel i with done[i]=0:
  - lat[i] increments by 1.
  - If out_valid[i]=1, done[i] is set and lat[i] freezes at its incremented value. A result on the k-th cycle after accept therefore gives latency k (minimum 1).
- MEASURE, error cases:
  - out_valid[i]=1 when done[i]=1 sets proto_err and does not alter lat[i].
  - in_valid=1 while in MEASURE sets proto_err; the transaction is ignored and not queued.
- Timeout: if any pending lat[i] reaches TIMEOUT, timeout is set, that channel is marked done with lat=TIMEOUT, and measurement continues for the other channels.
- When all done bits are 1, including bits set this cycle, the FSM goes to COMPARE on the next cycle.
- COMPARE (one cycle):
  - cmp_valid=1 and cmp_mask[i]=(lat[i]!=lat[0]); txn_count increments.
  - If any mask bit is set and mismatch=0: mismatch←1, first_op←latched op, first_lat0←lat[0].
  - first_op and first_lat0 never update again until reset.
  - FSM returns to IDLE; busy=0 in the same cycle as the COMPARE→IDLE transition.
  - in_valid during COMPARE sets proto_err and is dropped. The earliest legal back-to-back issue is the cycle after cmp_valid.
- Latency from last out_valid to cmp_valid: 1 cycle.
- Counters saturate at TIMEOUT and never wrap.

Optional Feature:
- Macro: LATENCY_MITER_OP_FILTER_EN.
- Defined:
  - Adds an input op_cmp_en, width 2^OP_W. Bit n=1 means opcode n participates in comparison; this is used to exclude NOP/illegal encodings whose timing is not constant-time.
  - Excluded transactions are still measured, still pulse cmp_valid, and still increment txn_count, but cmp_mask is forced to 0 and mismatch/first_* are unaffected.
  - timeout and proto_err are still reported for excluded transactions.
- Undefined: every transaction is compared; the port is absent.

Test Plan:
- N_CH=2: issue op=3; out_valid[0] and out_valid[1] both arrive 4 cycles after accept → cmp_valid one cycle later, cmp_mask=00, mismatch=0, txn_count=1.
- N_CH=3: issue op=7; ch0 at 33 cycles, ch1 at 33, ch2 at 5 → cmp_mask=100, mismatch=1, first_op=7, first_lat0=33. A second diverging op=8 leaves first_op=7.
- TIMEOUT=20: ch1 never responds, ch0 at 3 → timeout=1 at cycle 20, cmp_mask=10, mismatch=1.
- Protocol errors: in_valid while busy, and a second out_valid[0] after done → proto_err=1, lat unchanged, measured transaction completes normally.
- Reset: assert rst_n=0 mid-MEASURE after 10 cycles → all outputs 0 immediately. After release, a fresh op=0 with equal latencies yields txn_count=1.
- With LATENCY_MITER_OP_FILTER_EN, op_cmp_en bit 9=0: op=9 with latencies 2 and 6 → cmp_valid=1, cmp_mask=0, mismatch=0. Same stimulus with bit 9=1 → mismatch=1.
